uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Configurable UART receiver; next generation of the glitcher's fixed 8N1 receiver.
//  - Adds selectable data width, parity and stop-bit count.
//  - Adds an input synchroniser, 3-sample majority vote and start-bit glitch rejection.
//  - Reports parity, framing and break errors.
//  - Feeds the command decoder; one completed frame gives one data_valid_o pulse.
// PARAMETERS
//  CLK_FREQ     50_000_000  system clock frequency, Hz
//  BAUD_RATE    115200      line rate; CLKS_PER_BIT=CLK_FREQ/BAUD_RATE must be >=8 (elab error)
//  DATA_BITS    8           data bits per frame, 5..9
//  PARITY       0           0=none, 1=odd, 2=even
//  STOP_BITS    1           1 or 2
//  SYNC_STAGES  2           input synchroniser depth, >=2
// PORTS
//  clk           in   1          system clock
//  rst           in   1          reset, synchronous, active-high
//  rx_i          in   1          asynchronous serial line, idle high
//  data_o        out  DATA_BITS  last received word, LSB first on line
//  data_valid_o  out  1          1-cycle pulse: frame complete, data_o/error flags valid
//  parity_err_o  out  1          qualifies data_valid_o: parity mismatch
//  frame_err_o   out  1          qualifies data_valid_o: a stop bit sampled 0
//  break_o       out  1          qualifies data_valid_o: all data/parity/stop bits sampled 0
//  busy_o        out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset values
//  - data_o=0; data_valid_o=parity_err_o=frame_err_o=break_o=busy_o=0.
//  - Synchroniser flops=1; state=IDLE; counters=0.
//  - Reset mid-frame aborts the frame with no pulse.
//  Sampling
//  - rx_s = rx_i after SYNC_STAGES flops. hist[2:0] shifts rx_s every clk.
//  - Bit value = majority(hist) taken when clk_cnt==CLKS_PER_BIT-1 (strobe); clk_cnt then clears.
//  - clk_cnt width $clog2(CLKS_PER_BIT+1); no wrap: it clears on every strobe.
//  State machine: IDLE, START, DATA, PARITY, STOP, RECOVER
//  - IDLE: clk_cnt held 0; rx_s==0 -> START.
//  - START: clk_cnt==CLKS_PER_BIT/2-1 with rx_s==0 -> DATA, clk_cnt=0, bit_cnt=0.
//    rx_s==1 at any point before that -> IDLE (glitch rejected, no outputs).
//  - DATA: on strobe shift bit in at MSB of shift reg (LSB first).
//    bit_cnt==DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
//  - PARITY: on strobe capture p_bit.
//    Error when odd: ^data^p_bit != 1; when even: ^data^p_bit != 0.
//  - STOP: STOP_BITS strobes. Any stop sample 0 sets frame error; all are checked.
//    After the last strobe: -> IDLE if no frame error, else -> RECOVER.
//  - RECOVER: wait for rx_s==1, then IDLE. Held-low break lines never re-trigger.
//  Outputs
//  - Cycle after the final stop strobe: data_valid_o=1 for exactly 1 clk.
//  - In that same cycle: data_o loads word; parity_err_o/frame_err_o/break_o valid, else 0.
//  - data_valid_o fires even with errors; consumer discards on any flag.
//  - data_o holds between frames; it is not cleared at start bit.
//  - break_o implies frame_err_o. break_o also requires the parity bit 0 when PARITY!=0.
//  - busy_o is registered from state. It rises the cycle after the start edge reaches rx_s.
//  Latency
//  - Frame start edge on rx_i to data_valid_o is SYNC_STAGES+1+(0.5+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT clk, ±1.
//  - P = 1 if PARITY!=0, else 0.
//  - Back-to-back frames: the next start bit is accepted in the cycle after the last stop strobe.
// TESTING  (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> 10 clk/bit unless noted)
//  1 8N1, send 0x55 then 0xA3 back-to-back.
//    -> two pulses, data_o=0x55 then 0xA3, all flags 0, busy_o low only between frames.
//  2 8E1, send 0x07 with parity bit 0 (wrong).
//    -> pulse with data_o=0x07, parity_err_o=1. Correct parity bit 1 -> parity_err_o=0.
//  3 8N2, send 0x3C with second stop bit 0.
//    -> pulse, frame_err_o=1, busy_o stays high until rx_i returns 1.
//  4 Hold rx_i low 30 bit times.
//    -> exactly one pulse, data_o=0, frame_err_o=1, break_o=1; no further pulses.
//  5 3-clk low glitch on idle line -> no pulse, busy_o back to 0.
//    Invert 1 clk at each sample point of 0x96 -> data_o=0x96.
//  6 Assert rst for 1 clk mid-DATA of a frame -> all outputs 0, no pulse.
//    Next clean 0xC5 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: input synchroniser, 3-sample majority vote, start-glitch
// rejection, selectable data width / parity / stop bits, parity/framing/break reporting.
module uart_rx_cfg #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_bad_rate
            $error("uart_rx_cfg: CLK_FREQ/BAUD_RATE must be >= 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
            $error("uart_rx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("uart_rx_cfg: SYNC_STAGES must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             hist;
    logic                   rx_s;
    logic                   bit_val;
    logic                   strobe;
    logic                   done;
    logic [CNT_W-1:0]       clk_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [1:0]             stop_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   p_bit;
    logic                   ferr_q;
    logic                   any_one;
    logic                   ferr_n;
    logic                   par_err;
    logic                   brk_n;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign bit_val = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign strobe  = (clk_cnt == CNT_LAST);

    // Flags for the frame being closed by the final stop strobe.
    assign ferr_n  = ferr_q | ~bit_val;
    assign brk_n   = ~(any_one | bit_val);
    assign par_err = (PARITY == 1) ? ~(^shreg ^ p_bit) :
                     (PARITY == 2) ?  (^shreg ^ p_bit) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist   <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            hist   <= {hist[1:0], rx_s};
        end
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            S_IDLE:    if (!rx_s) state_n = S_START;
            S_START: begin
                if (rx_s)                     state_n = S_IDLE;
                else if (clk_cnt == CNT_HALF) state_n = S_DATA;
            end
            S_DATA: begin
                if (strobe && bit_cnt == BIT_LAST)
                    state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY:  if (strobe) state_n = S_STOP;
            S_STOP: begin
                if (strobe && stop_cnt == STOP_LAST) begin
                    done    = 1'b1;
                    state_n = ferr_n ? S_RECOVER : S_IDLE;
                end
            end
            // A line held low after a bad frame must go high before we re-arm.
            S_RECOVER: if (rx_s) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= '0;
            shreg        <= '0;
            p_bit        <= 1'b0;
            ferr_q       <= 1'b0;
            any_one      <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= state_n;
            busy_o       <= (state_n != S_IDLE);
            data_valid_o <= done;
            parity_err_o <= done & par_err;
            frame_err_o  <= done & ferr_n;
            break_o      <= done & brk_n;
            if (done) data_o <= shreg;

            case (state)
                S_IDLE, S_RECOVER: clk_cnt <= '0;
                S_START: clk_cnt <= (state_n == S_START) ? clk_cnt + 1'b1 : '0;
                default: clk_cnt <= strobe ? '0 : clk_cnt + 1'b1;
            endcase

            if (state == S_START && state_n == S_DATA) begin
                bit_cnt  <= '0;
                stop_cnt <= '0;
                ferr_q   <= 1'b0;
                any_one  <= 1'b0;
                p_bit    <= 1'b0;
            end else if (strobe) begin
                case (state)
                    S_DATA: begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        any_one <= any_one | bit_val;
                    end
                    S_PARITY: begin
                        p_bit   <= bit_val;
                        any_one <= any_one | bit_val;
                    end
                    S_STOP: begin
                        stop_cnt <= stop_cnt + 1'b1;
                        ferr_q   <= ferr_n;
                        any_one  <= any_one | bit_val;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
